// File: rtl/arm_mem_responder.sv
// Memory-side responder for the core's external bus.
// Accepts one request at a time, stalls the core for WAIT_STATES cycles, then
// spends one DONE cycle returning read data or committing write data. The RAM
// is word-organised, and byte and halfword accesses use little-endian lane steering.
// An address beyond the RAM raises ABORT for the DONE cycle. The access then has
// no effect on the RAM.
module arm_mem_responder #(
  parameter int    ADDR_WIDTH  = 12,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        sysclk,
  input  logic        nRESET,
  input  logic        nMREQ,
  input  logic        nRW,
  input  logic [1:0]  MAS,
  input  logic [31:0] A,
  input  logic [31:0] DIN,
  output logic [31:0] DOUT,
  output logic        nWAIT,
  output logic        ABORT
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // The counter is loaded with WAIT_STATES-1, so it reaches zero in the last WAIT cycle.
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic        rw_q;
  logic [1:0]  mas_q;
  logic [31:0] dout_q;
  logic        nwait_q;
  logic        abort_q;

  logic [31:0] mem [DEPTH];

  // Any set bit above the RAM's byte-address range makes the access out of range.
  function automatic logic out_of_range(input logic [31:0] addr);
    return (addr >> (ADDR_WIDTH + 2)) != 32'd0;
  endfunction

  // Read lane steering: a byte is replicated x4, a halfword x2, and a word passes through.
  function automatic logic [31:0] steer_read(input logic [31:0] w, input logic [1:0] m,
                                             input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (m)
      2'b00:   r = {4{b}};
      2'b01:   r = {2{h}};
      default: r = w;
    endcase
    return r;
  endfunction

  // Write lane merge: only the addressed lanes of the old word are replaced.
  function automatic logic [31:0] merge_write(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] m, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (m)
      2'b00: begin
        case (lane)
          2'd0:    r[7:0]   = d[7:0];
          2'd1:    r[15:8]  = d[7:0];
          2'd2:    r[23:16] = d[7:0];
          default: r[31:24] = d[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) r[31:16] = d[15:0];
        else         r[15:0]  = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Write commit path. A write leaves DONE on the same edge that may register the next read.
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [31:0]           wr_word;

  assign wr_en   = (state_q == ST_DONE) && rw_q && !out_of_range(addr_q);
  assign wr_idx  = addr_q[ADDR_WIDTH+1:2];
  assign wr_word = merge_write(mem[wr_idx], DIN, mas_q, addr_q[1:0]);

  // Read path into DONE. From WAIT it uses the latched request.
  // With no wait states, the request enters DONE from IDLE or DONE. It then uses
  // the live bus.
  logic [31:0]           rd_addr;
  logic [1:0]            rd_mas;
  logic                  rd_is_read;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [31:0]           rd_word;
  logic                  rd_oor;
  logic [31:0]           rd_data;

  assign rd_addr    = (state_q == ST_WAIT) ? addr_q : A;
  assign rd_mas     = (state_q == ST_WAIT) ? mas_q  : MAS;
  assign rd_is_read = (state_q == ST_WAIT) ? !rw_q  : !nRW;
  assign rd_idx     = rd_addr[ADDR_WIDTH+1:2];
  // A write that commits on this edge is forwarded, so a back-to-back read sees the new data.
  assign rd_word    = (wr_en && (wr_idx == rd_idx)) ? wr_word : mem[rd_idx];
  assign rd_oor     = out_of_range(rd_addr);
  assign rd_data    = rd_oor ? 32'd0 : steer_read(rd_word, rd_mas, rd_addr[1:0]);

  // Request FSM; nWAIT, ABORT and DOUT are registered alongside the state.
  // NOTE: all state and output registers use non-blocking assignments, so every branch sees pre-edge values.
  always_ff @(posedge sysclk or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      rw_q    <= 1'b0;
      mas_q   <= 2'b00;
      dout_q  <= 32'd0;
      nwait_q <= 1'b1;
      abort_q <= 1'b0;
    end else begin
      nwait_q <= 1'b1;
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (!nMREQ) begin
            addr_q <= A;
            rw_q   <= nRW;
            mas_q  <= MAS;
            if (WAIT_STATES > 0) begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_LOAD;
              nwait_q <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              abort_q <= rd_oor;
              if (rd_is_read) dout_q <= rd_data;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_DONE;
            abort_q <= rd_oor;
            if (rd_is_read) dout_q <= rd_data;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
            nwait_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // RAM write port. It commits only on the edge that leaves DONE.
  // NOTE: the RAM array is deliberately not reset; its contents survive nRESET.
  always_ff @(posedge sysclk) begin
    if (wr_en) mem[wr_idx] <= wr_word;
  end

  assign DOUT  = dout_q;
  assign nWAIT = nwait_q;
  assign ABORT = abort_q;

endmodule

// File: tb/tb_arm_mem_responder.sv
// Bench for arm_mem_responder. Instance 0 has no wait states and instance 1 has one.
// The reference model is a flat byte-addressed RAM with little-endian rules.
module tb_arm_mem_responder;

  localparam int NB = 16384;  // bytes in a RAM with ADDR_WIDTH=12

  logic        clk;
  logic        nrst  [2];
  logic        nmreq [2];
  logic        nrw   [2];
  logic [1:0]  mas   [2];
  logic [31:0] a     [2];
  logic [31:0] din   [2];
  logic [31:0] dout  [2];
  logic        nwait [2];
  logic        abort [2];

  int checks   = 0;
  int failures = 0;

  logic [7:0] mdl [2][NB];

  typedef struct {
    bit          wr;
    logic [1:0]  m;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  arm_mem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u_ws0 (
    .sysclk(clk), .nRESET(nrst[0]), .nMREQ(nmreq[0]), .nRW(nrw[0]), .MAS(mas[0]),
    .A(a[0]), .DIN(din[0]), .DOUT(dout[0]), .nWAIT(nwait[0]), .ABORT(abort[0]));

  arm_mem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(1)) u_ws1 (
    .sysclk(clk), .nRESET(nrst[1]), .nMREQ(nmreq[1]), .nRW(nrw[1]), .MAS(mas[1]),
    .A(a[1]), .DIN(din[1]), .DOUT(dout[1]), .nWAIT(nwait[1]), .ABORT(abort[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit oor(input logic [31:0] addr);
    return addr >= 32'(NB);
  endfunction

  function automatic logic [31:0] mread(input int d, input logic [31:0] addr, input logic [1:0] m);
    int base;
    if (oor(addr)) return 32'd0;
    if (m == 2'b00) return {4{mdl[d][int'(addr)]}};
    if (m == 2'b01) begin
      base = int'(addr) & ~1;
      return {2{mdl[d][base+1], mdl[d][base]}};
    end
    base = int'(addr) & ~3;
    return {mdl[d][base+3], mdl[d][base+2], mdl[d][base+1], mdl[d][base]};
  endfunction

  task automatic mwrite(input int d, input logic [31:0] addr, input logic [1:0] m,
                        input logic [31:0] data);
    int n;
    int base;
    if (oor(addr)) return;
    n    = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
    base = int'(addr) & ~(n - 1);
    for (int i = 0; i < n; i++) mdl[d][base+i] = data[8*i +: 8];
  endtask

  // One isolated access. It counts the nWAIT-low cycles and samples DOUT/ABORT in DONE.
  task automatic bus_access(input int d, input bit wr, input logic [1:0] m,
                            input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] rd, output logic ab, output int lows,
                            output bit to);
    @(negedge clk);
    nmreq[d] = 1'b0; nrw[d] = wr; mas[d] = m; a[d] = addr; din[d] = data;
    @(posedge clk); #1;
    nmreq[d] = 1'b1;
    lows = 0; to = 1'b1; ab = 1'b0; rd = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (nwait[d] === 1'b1) begin
        rd = dout[d]; ab = abort[d]; to = 1'b0;
        break;
      end
      lows++;
    end
    @(posedge clk); #1;
    if (!to && wr) mwrite(d, addr, m, data);
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      nrst[d] = 1'b0; nmreq[d] = 1'b1; nrw[d] = 1'b0; mas[d] = 2'b10; a[d] = '0; din[d] = '0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      checks++; if (nwait[d] !== 1'b1) begin failures++; $display("FAIL reset_nwait[%0d]: got %b expected 1", d, nwait[d]); end
      checks++; if (dout[d] !== 32'd0) begin failures++; $display("FAIL reset_dout[%0d]: got %h expected 0", d, dout[d]); end
      checks++; if (abort[d] !== 1'b0) begin failures++; $display("FAIL reset_abort[%0d]: got %b expected 0", d, abort[d]); end
    end
    @(negedge clk);
    nrst[0] = 1'b1; nrst[1] = 1'b1;
  endtask

  task automatic test_word_rw;
    logic [31:0] rd; logic ab; int lows; bit to;
    bus_access(1, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF, rd, ab, lows, to);
    checks++; if (to || lows != 1) begin failures++; $display("FAIL word_wr_wait: got %0d timeout=%0d expected 1", lows, to); end
    checks++; if (ab !== 1'b0) begin failures++; $display("FAIL word_wr_abort: got %b expected 0", ab); end
    bus_access(1, 1'b0, 2'b10, 32'h100, 32'h0, rd, ab, lows, to);
    checks++; if (to || lows != 1) begin failures++; $display("FAIL word_rd_wait: got %0d timeout=%0d expected 1", lows, to); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL word_rd: got %h expected deadbeef", rd); end
  endtask

  task automatic test_byte_lane;
    logic [31:0] rd; logic ab; int lows; bit to;
    bus_access(1, 1'b1, 2'b00, 32'h101, 32'h000000AB, rd, ab, lows, to);
    bus_access(1, 1'b0, 2'b10, 32'h100, 32'h0, rd, ab, lows, to);
    checks++; if (rd !== 32'hDEADABEF) begin failures++; $display("FAIL byte_wr: got %h expected deadabef", rd); end
    bus_access(1, 1'b0, 2'b00, 32'h103, 32'h0, rd, ab, lows, to);
    checks++; if (rd !== 32'hDEDEDEDE) begin failures++; $display("FAIL byte_rd: got %h expected dededede", rd); end
  endtask

  task automatic test_halfword;
    logic [31:0] rd; logic ab; int lows; bit to;
    bus_access(1, 1'b0, 2'b01, 32'h102, 32'h0, rd, ab, lows, to);
    checks++; if (rd !== 32'hDEADDEAD) begin failures++; $display("FAIL half_rd: got %h expected deaddead", rd); end
    bus_access(1, 1'b1, 2'b01, 32'h103, 32'h00001234, rd, ab, lows, to);
    bus_access(1, 1'b0, 2'b10, 32'h100, 32'h0, rd, ab, lows, to);
    checks++; if (rd !== 32'h1234ABEF) begin failures++; $display("FAIL half_wr: got %h expected 1234abef", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic ab; int lows; bit to;
    logic [31:0] exp_w [3];
    for (int i = 0; i < 3; i++) begin
      exp_w[i] = $urandom;
      bus_access(0, 1'b1, 2'b10, 32'(4 * i), exp_w[i], rd, ab, lows, to);
      checks++; if (to || lows != 0) begin failures++; $display("FAIL ws0_wait[%0d]: got %0d timeout=%0d expected 0", i, lows, to); end
    end
    @(negedge clk);
    nmreq[0] = 1'b0; nrw[0] = 1'b0; mas[0] = 2'b10; a[0] = 32'h0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (nwait[0] !== 1'b1) begin failures++; $display("FAIL b2b_nwait[%0d]: got %b expected 1", i - 1, nwait[0]); end
      checks++; if (dout[0] !== exp_w[i-1]) begin failures++; $display("FAIL b2b_dout[%0d]: got %h expected %h", i - 1, dout[0], exp_w[i-1]); end
      if (i < 3) a[0] = 32'(4 * i);
      else nmreq[0] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic init_region(input int d);
    logic [31:0] rd; logic ab; int lows; bit to;
    for (int w = 0; w < 16; w++) begin
      bus_access(d, 1'b1, 2'b10, 32'h400 + 32'(4 * w), $urandom, rd, ab, lows, to);
      checks++; if (to) begin failures++; $display("FAIL init_timeout[%0d]: got timeout expected completion", d); end
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.wr   = 1'($urandom_range(0, 1));
    t.m    = 2'($urandom_range(0, 3));
    t.addr = 32'h400 + 32'($urandom_range(0, 63));
    if ($urandom_range(0, 7) == 0) t.addr = t.addr | 32'h0001_0000;
    t.data = $urandom;
    return t;
  endfunction

  task automatic test_random_single;
    logic [31:0] rd; logic ab; int lows; bit to;
    txn_t t;
    logic [31:0] exp_rd;
    init_region(1);
    for (int i = 0; i < 30; i++) begin
      t = rand_txn();
      exp_rd = mread(1, t.addr, t.m);
      bus_access(1, t.wr, t.m, t.addr, t.data, rd, ab, lows, to);
      checks++; if (to || lows != 1) begin failures++; $display("FAIL rnd_wait[%0d]: got %0d timeout=%0d expected 1", i, lows, to); end
      checks++; if (ab !== oor(t.addr)) begin failures++; $display("FAIL rnd_abort[%0d]: got %b expected %b", i, ab, oor(t.addr)); end
      if (!t.wr) begin
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rnd_rd[%0d]: addr %h mas %0d got %h expected %h", i, t.addr, t.m, rd, exp_rd); end
      end
    end
  endtask

  task automatic test_random_b2b;
    txn_t q [40];
    logic [31:0] exp_rd;
    init_region(0);
    for (int i = 0; i < 40; i++) q[i] = rand_txn();
    @(negedge clk);
    nmreq[0] = 1'b0; nrw[0] = q[0].wr; mas[0] = q[0].m; a[0] = q[0].addr; din[0] = q[0].data;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checks++; if (nwait[0] !== 1'b1) begin failures++; $display("FAIL rb2b_nwait[%0d]: got %b expected 1", i - 1, nwait[0]); end
      checks++; if (abort[0] !== oor(q[i-1].addr)) begin failures++; $display("FAIL rb2b_abort[%0d]: got %b expected %b", i - 1, abort[0], oor(q[i-1].addr)); end
      if (!q[i-1].wr) begin
        exp_rd = mread(0, q[i-1].addr, q[i-1].m);
        checks++; if (dout[0] !== exp_rd) begin failures++; $display("FAIL rb2b_rd[%0d]: addr %h mas %0d got %h expected %h", i - 1, q[i-1].addr, q[i-1].m, dout[0], exp_rd); end
      end else begin
        mwrite(0, q[i-1].addr, q[i-1].m, q[i-1].data);
      end
      din[0] = q[i-1].data;
      if (i < 40) begin
        nrw[0] = q[i].wr; mas[0] = q[i].m; a[0] = q[i].addr;
      end else begin
        nmreq[0] = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; logic ab; int lows; bit to;
    bus_access(1, 1'b1, 2'b10, 32'h0, 32'h55AA55AA, rd, ab, lows, to);
    bus_access(1, 1'b1, 2'b10, 32'h0001_0000, 32'hFFFFFFFF, rd, ab, lows, to);
    checks++; if (ab !== 1'b1) begin failures++; $display("FAIL oor_wr_abort: got %b expected 1", ab); end
    checks++; if (to || lows != 1) begin failures++; $display("FAIL oor_wr_wait: got %0d timeout=%0d expected 1", lows, to); end
    @(negedge clk);
    checks++; if (abort[1] !== 1'b0) begin failures++; $display("FAIL oor_abort_one_cycle: got %b expected 0", abort[1]); end
    bus_access(1, 1'b0, 2'b10, 32'h0, 32'h0, rd, ab, lows, to);
    checks++; if (rd !== 32'h55AA55AA) begin failures++; $display("FAIL oor_no_alias: got %h expected 55aa55aa", rd); end
    bus_access(1, 1'b0, 2'b10, 32'h0001_0000, 32'h0, rd, ab, lows, to);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL oor_rd_dout: got %h expected 0", rd); end
    checks++; if (ab !== 1'b1) begin failures++; $display("FAIL oor_rd_abort: got %b expected 1", ab); end
    bus_access(1, 1'b1, 2'b10, 32'h3FFC, 32'h0BADCAFE, rd, ab, lows, to);
    bus_access(1, 1'b0, 2'b10, 32'h3FFC, 32'h0, rd, ab, lows, to);
    checks++; if (ab !== 1'b0 || rd !== 32'h0BADCAFE) begin failures++; $display("FAIL top_word: got %h abort=%b expected 0badcafe abort=0", rd, ab); end
    bus_access(1, 1'b0, 2'b00, 32'h4000, 32'h0, rd, ab, lows, to);
    checks++; if (ab !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL first_oor: got %h abort=%b expected 0 abort=1", rd, ab); end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] rd; logic ab; int lows; bit to;
    bus_access(1, 1'b1, 2'b10, 32'h200, 32'h11112222, rd, ab, lows, to);
    bus_access(1, 1'b0, 2'b10, 32'h200, 32'h0, rd, ab, lows, to);
    @(negedge clk);
    nmreq[1] = 1'b0; nrw[1] = 1'b1; mas[1] = 2'b10; a[1] = 32'h200; din[1] = 32'hCAFEF00D;
    @(posedge clk); #1;
    nmreq[1] = 1'b1;
    checks++; if (nwait[1] !== 1'b0) begin failures++; $display("FAIL midwait_nwait_low: got %b expected 0", nwait[1]); end
    #1 nrst[1] = 1'b0;
    #1;
    checks++; if (nwait[1] !== 1'b1) begin failures++; $display("FAIL midwait_rst_nwait: got %b expected 1", nwait[1]); end
    checks++; if (dout[1] !== 32'd0) begin failures++; $display("FAIL midwait_rst_dout: got %h expected 0", dout[1]); end
    @(posedge clk);
    @(negedge clk);
    nrst[1] = 1'b1;
    bus_access(1, 1'b0, 2'b10, 32'h200, 32'h0, rd, ab, lows, to);
    checks++; if (rd !== 32'h11112222) begin failures++; $display("FAIL midwait_discard: got %h expected 11112222", rd); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lane();
    test_halfword();
    test_back_to_back();
    test_random_single();
    test_random_b2b();
    test_out_of_range();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
